// File: rtl/sme_job_sched.sv
// sme_job_sched: shares one string-matching engine between two byte-stream clients.
// A round-robin arbiter picks a client. The FSM waits for the engine to re-enter its
// Load phase, then forwards the client's string and pattern bytes while checking their
// order and length. It captures the engine verdict and returns it tagged with the
// client id. Only the engine/ack path is combinational; every other output is registered.
module sme_job_sched #(
    parameter int TIMEOUT = 1024,
    parameter int MAX_STR = 32,
    parameter int MAX_PAT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] c_req,
    input  logic [7:0] c0_data,
    input  logic [2:0] c0_flags,
    input  logic [7:0] c1_data,
    input  logic [2:0] c1_flags,
    output logic [1:0] c_gnt,
    output logic [1:0] c_ack,
    output logic [7:0] eng_chardata,
    output logic       eng_isstring,
    output logic       eng_ispattern,
    input  logic       eng_valid,
    input  logic       eng_match,
    input  logic [4:0] eng_index,
    output logic       res_valid,
    output logic       res_id,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       res_err
);

    localparam int TMO_W = $clog2(TIMEOUT) + 1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ARB  = 3'd1;
    localparam logic [2:0] ST_SYNC = 3'd2;
    localparam logic [2:0] ST_XFER = 3'd3;
    localparam logic [2:0] ST_WAIT = 3'd4;
    localparam logic [2:0] ST_RESP = 3'd5;

    localparam logic [5:0]       MAX_STR_C = 6'(MAX_STR);
    localparam logic [3:0]       MAX_PAT_C = 4'(MAX_PAT);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

    // state registers
    logic [2:0]       st_reg, st_next;
    logic [1:0]       c_gnt_reg, c_gnt_next;
    logic             rr_reg, rr_next;          // client favoured on a tie
    logic [5:0]       str_cnt_reg, str_cnt_next;
    logic [3:0]       pat_cnt_reg, pat_cnt_next;
    logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic             err_reg, err_next;        // sticky job error
    logic             res_valid_reg, res_valid_next;
    logic             res_id_reg, res_id_next;
    logic             res_match_reg, res_match_next;
    logic [4:0]       res_index_reg, res_index_next;
    logic             res_err_reg, res_err_next;

    // datapath of the byte currently offered by the granted client
    logic             gid;
    logic [7:0]       sel_data;
    logic [2:0]       sel_flags;
    logic             sel_last, sel_pat, sel_str;
    logic             fwd;
    logic             bubble;
    logic             str_order_err, str_ovf, pat_ovf;
    logic             drop;
    logic             pass;
    logic             byte_err;
    logic             wait_err;
    logic [TMO_W-1:0] tmo_inc;

    assign gid       = c_gnt_reg[1];
    assign sel_data  = gid ? c1_data  : c0_data;
    assign sel_flags = gid ? c1_flags : c0_flags;
    assign sel_last  = sel_flags[2];
    assign sel_pat   = sel_flags[1];
    assign sel_str   = sel_flags[0];

    // A byte is consumed every XFER cycle, and in SYNC only on the engine's Load strobe
    assign fwd = (st_reg == ST_XFER) | ((st_reg == ST_SYNC) & eng_valid);

    // A string byte after any forwarded pattern byte breaks the engine's Load order
    assign str_order_err = sel_str & (pat_cnt_reg != 4'd0);
    assign str_ovf       = sel_str & (str_cnt_reg >= MAX_STR_C);
    assign pat_ovf       = sel_pat & (pat_cnt_reg >= MAX_PAT_C);
    assign bubble        = ~sel_str & ~sel_pat;
    assign drop          = str_order_err | str_ovf | pat_ovf;
    assign pass          = fwd & ~drop;
    assign byte_err      = drop | bubble;

    // A job that never delivered a pattern byte still runs, but its verdict is flagged
    assign wait_err = err_reg | (pat_cnt_reg == 4'd0);

    assign tmo_inc = (tmo_cnt_reg == '1) ? tmo_cnt_reg : tmo_cnt_reg + TMO_W'(1);

    // Dropped bytes reach the engine as idle cycles (all zero)
    assign eng_chardata  = (pass & (sel_str | sel_pat)) ? sel_data : 8'h00;
    assign eng_isstring  = pass & sel_str;
    assign eng_ispattern = pass & sel_pat;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ack
            assign c_ack[gi] = c_gnt_reg[gi] & fwd;
        end
    endgenerate

    assign c_gnt     = c_gnt_reg;
    assign res_valid = res_valid_reg;
    assign res_id    = res_id_reg;
    assign res_match = res_match_reg;
    assign res_index = res_index_reg;
    assign res_err   = res_err_reg;

    // next-state, counter and result computation
    always_comb begin
        st_next        = st_reg;
        c_gnt_next     = c_gnt_reg;
        rr_next        = rr_reg;
        str_cnt_next   = str_cnt_reg;
        pat_cnt_next   = pat_cnt_reg;
        tmo_cnt_next   = tmo_cnt_reg;
        err_next       = err_reg;
        res_valid_next = 1'b0;
        res_id_next    = res_id_reg;
        res_match_next = res_match_reg;
        res_index_next = res_index_reg;
        res_err_next   = res_err_reg;

        // byte accounting for whatever the client handed over this cycle
        if (fwd) begin
            if (pass & sel_str & (str_cnt_reg != 6'h3f)) begin
                str_cnt_next = str_cnt_reg + 6'd1;
            end
            if (pass & sel_pat & (pat_cnt_reg != 4'hf)) begin
                pat_cnt_next = pat_cnt_reg + 4'd1;
            end
            if (byte_err) begin
                err_next = 1'b1;
            end
        end

        case (st_reg)
            ST_IDLE: begin
                if (|c_req) begin
                    st_next = ST_ARB;
                end
            end
            ST_ARB: begin
                str_cnt_next = 6'd0;
                pat_cnt_next = 4'd0;
                tmo_cnt_next = '0;
                err_next     = 1'b0;
                if (c_req == 2'b00) begin
                    st_next = ST_IDLE;
                end else begin
                    // on a tie the favoured client wins; otherwise the lone requester
                    if ((c_req == 2'b11) ? rr_reg : c_req[1]) begin
                        c_gnt_next = 2'b10;
                    end else begin
                        c_gnt_next = 2'b01;
                    end
                    st_next = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (eng_valid) begin
                    tmo_cnt_next = '0;
                    st_next      = (sel_last | bubble) ? ST_WAIT : ST_XFER;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    st_next        = ST_RESP;
                    res_valid_next = 1'b1;
                    res_id_next    = gid;
                    res_match_next = 1'b0;
                    res_index_next = 5'd0;
                    res_err_next   = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_inc;
                end
            end
            ST_XFER: begin
                if (sel_last | bubble) begin
                    tmo_cnt_next = '0;
                    st_next      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // the strobe in the first WAIT cycle belongs to the previous Check
                if (eng_valid && (tmo_cnt_reg != '0)) begin
                    st_next        = ST_RESP;
                    res_valid_next = 1'b1;
                    res_id_next    = gid;
                    res_match_next = wait_err ? 1'b0 : eng_match;
                    res_index_next = wait_err ? 5'd0 : eng_index;
                    res_err_next   = wait_err;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    st_next        = ST_RESP;
                    res_valid_next = 1'b1;
                    res_id_next    = gid;
                    res_match_next = 1'b0;
                    res_index_next = 5'd0;
                    res_err_next   = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_inc;
                end
            end
            ST_RESP: begin
                c_gnt_next = 2'b00;
                rr_next    = ~gid;
                st_next    = ST_IDLE;
            end
            default: begin
                c_gnt_next = 2'b00;
                st_next    = ST_IDLE;
            end
        endcase
    end

    // register update; reset abandons any job without reporting it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_reg        <= ST_IDLE;
            c_gnt_reg     <= 2'b00;
            rr_reg        <= 1'b0;
            str_cnt_reg   <= 6'd0;
            pat_cnt_reg   <= 4'd0;
            tmo_cnt_reg   <= '0;
            err_reg       <= 1'b0;
            res_valid_reg <= 1'b0;
            res_id_reg    <= 1'b0;
            res_match_reg <= 1'b0;
            res_index_reg <= 5'd0;
            res_err_reg   <= 1'b0;
        end else begin
            st_reg        <= st_next;
            c_gnt_reg     <= c_gnt_next;
            rr_reg        <= rr_next;
            str_cnt_reg   <= str_cnt_next;
            pat_cnt_reg   <= pat_cnt_next;
            tmo_cnt_reg   <= tmo_cnt_next;
            err_reg       <= err_next;
            res_valid_reg <= res_valid_next;
            res_id_reg    <= res_id_next;
            res_match_reg <= res_match_next;
            res_index_reg <= res_index_next;
            res_err_reg   <= res_err_next;
        end
    end

endmodule

// File: tb/tb_sme_job_sched.sv
// Testbench for sme_job_sched: a cycle table for one complete job, then client and
// engine models for arbitration, timeout, overflow, ordering, bubble and reset cases.
module tb_sme_job_sched;

    localparam int TIMEOUT = 1024;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] c_req;
    logic [7:0] c0_data, c1_data;
    logic [2:0] c0_flags, c1_flags;
    logic [1:0] c_gnt, c_ack;
    logic [7:0] eng_chardata;
    logic       eng_isstring, eng_ispattern;
    logic       eng_valid, eng_match;
    logic [4:0] eng_index;
    logic       res_valid, res_id, res_match, res_err;
    logic [4:0] res_index;

    always #5 clk = ~clk;

    sme_job_sched #(.TIMEOUT(TIMEOUT), .MAX_STR(32), .MAX_PAT(8)) dut (
        .clk(clk), .reset(reset), .c_req(c_req),
        .c0_data(c0_data), .c0_flags(c0_flags), .c1_data(c1_data), .c1_flags(c1_flags),
        .c_gnt(c_gnt), .c_ack(c_ack),
        .eng_chardata(eng_chardata), .eng_isstring(eng_isstring), .eng_ispattern(eng_ispattern),
        .eng_valid(eng_valid), .eng_match(eng_match), .eng_index(eng_index),
        .res_valid(res_valid), .res_id(res_id), .res_match(res_match),
        .res_index(res_index), .res_err(res_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // one cycle of the hand-computed table
    typedef struct {
        logic [1:0] req;
        logic [7:0] d0;
        logic [2:0] f0;
        logic       ev;
        logic       em;
        logic [4:0] ei;
        logic [1:0] gnt;
        logic [1:0] ack;
        logic [7:0] cd;
        logic       es;
        logic       ep;
        logic       rv;
        logic       rid;
        logic       rm;
        logic [4:0] ri;
        logic       re;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic [1:0] req, input logic [7:0] d0, input logic [2:0] f0,
                                input logic ev, input logic em, input logic [4:0] ei,
                                input logic [1:0] gnt, input logic [1:0] ack, input logic [7:0] cd,
                                input logic es, input logic ep, input logic rv, input logic rid,
                                input logic rm, input logic [4:0] ri, input logic re);
        vec_t v;
        v.req = req; v.d0 = d0; v.f0 = f0; v.ev = ev; v.em = em; v.ei = ei;
        v.gnt = gnt; v.ack = ack; v.cd = cd; v.es = es; v.ep = ep;
        v.rv = rv; v.rid = rid; v.rm = rm; v.ri = ri; v.re = re;
        return v;
    endfunction

    // client models: {flags, data} per byte
    logic [10:0] job0 [16];
    logic [10:0] job1 [16];
    int len0, len1, idx0, idx1;

    // engine model: free-running result strobe every eng_per cycles
    logic       eng_on;
    int         eng_per;
    logic       eng_m;
    logic [4:0] eng_i;
    logic       kill_after_ack;

    // observations
    int         cyc, acks0, acks1, str_cyc, pat_cyc, res_n, last_ack_cyc, res_cyc, fwd_n;
    logic [1:0] first_gnt;
    logic [7:0] fwd_log [64];
    logic       r_id [4];
    logic       r_m [4];
    logic [4:0] r_i [4];
    logic       r_e [4];

    task automatic clear_stats();
        cyc = 0; acks0 = 0; acks1 = 0; str_cyc = 0; pat_cyc = 0; res_n = 0;
        last_ack_cyc = 0; res_cyc = 0; fwd_n = 0; first_gnt = 2'b00;
        idx0 = 0; idx1 = 0;
    endtask

    // one clock: drive at posedge+1, observe at negedge, return at next posedge+1
    task automatic step();
        c0_data  = (idx0 < len0) ? job0[idx0][7:0]  : 8'h00;
        c0_flags = (idx0 < len0) ? job0[idx0][10:8] : 3'b000;
        c1_data  = (idx1 < len1) ? job1[idx1][7:0]  : 8'h00;
        c1_flags = (idx1 < len1) ? job1[idx1][10:8] : 3'b000;
        eng_valid = eng_on && ((cyc % eng_per) == 0);
        eng_match = eng_m;
        eng_index = eng_i;
        @(negedge clk);
        if (first_gnt == 2'b00) first_gnt = c_gnt;
        if (c_ack[0]) begin
            acks0++; idx0++; last_ack_cyc = cyc;
            if (kill_after_ack) eng_on = 1'b0;
        end
        if (c_ack[1]) begin
            acks1++; idx1++; last_ack_cyc = cyc;
            if (kill_after_ack) eng_on = 1'b0;
        end
        if (eng_isstring) str_cyc++;
        if (eng_ispattern) pat_cyc++;
        if ((eng_isstring || eng_ispattern) && fwd_n < 64) begin
            fwd_log[fwd_n] = eng_chardata;
            fwd_n++;
        end
        if (res_valid) begin
            if (res_n < 4) begin
                r_id[res_n] = res_id; r_m[res_n] = res_match;
                r_i[res_n] = res_index; r_e[res_n] = res_err;
            end
            $display("result %0d: id=%0d match=%0d index=%0d err=%0d cycle=%0d",
                     res_n, res_id, res_match, res_index, res_err, cyc);
            res_n++;
            res_cyc = cyc;
            c_req[res_id] = 1'b0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (res_n < n && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (res_n < n) begin
            failures++;
            $display("FAIL %s_no_result results=%0d required=%0d", name, res_n, n);
        end
    endtask

    task automatic chk_res(input string name, input int n, input logic id, input logic m,
                           input logic [4:0] i, input logic e);
        if (n < res_n && n < 4) begin
            chk({name, "_id"},    32'(r_id[n]), 32'(id));
            chk({name, "_match"}, 32'(r_m[n]),  32'(m));
            chk({name, "_index"}, 32'(r_i[n]),  32'(i));
            chk({name, "_err"},   32'(r_e[n]),  32'(e));
        end else begin
            checks++; failures++;
            $display("FAIL %s_missing results=%0d required_index=%0d", name, res_n, n);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        c_req = 2'b00;
        c0_data = 8'h00; c0_flags = 3'b000; c1_data = 8'h00; c1_flags = 3'b000;
        eng_valid = 1'b0; eng_match = 1'b0; eng_index = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // "ab ca" + "^ca" on client 0
    task automatic load_job_a();
        job0[0] = {3'b001, 8'h61}; job0[1] = {3'b001, 8'h62}; job0[2] = {3'b001, 8'h20};
        job0[3] = {3'b001, 8'h63}; job0[4] = {3'b001, 8'h61}; job0[5] = {3'b010, 8'h5e};
        job0[6] = {3'b010, 8'h63}; job0[7] = {3'b110, 8'h61};
        len0 = 8;
    endtask

    // short jobs on both clients: c0 "ab"+"b", c1 "xy"+"y"
    task automatic load_pair();
        job0[0] = {3'b001, 8'h61}; job0[1] = {3'b001, 8'h62}; job0[2] = {3'b110, 8'h62};
        job1[0] = {3'b001, 8'h78}; job1[1] = {3'b001, 8'h79}; job1[2] = {3'b110, 8'h79};
        len0 = 3; len1 = 3;
    endtask

    logic [7:0] exp_a [8];
    logic [7:0] exp_b [6];
    logic [7:0] exp_f [4];

    initial begin
        exp_a = '{8'h61, 8'h62, 8'h20, 8'h63, 8'h61, 8'h5e, 8'h63, 8'h61};
        exp_b = '{8'h61, 8'h62, 8'h62, 8'h78, 8'h79, 8'h79};
        exp_f = '{8'h61, 8'h62, 8'h78, 8'h79};
        eng_on = 1'b0; eng_per = 7; eng_m = 1'b0; eng_i = 5'd0; kill_after_ack = 1'b0;
        len0 = 0; len1 = 0;
        clear_stats();

        // ---- reset values ----
        reset = 1'b1;
        c_req = 2'b00;
        c0_data = 8'h00; c0_flags = 3'b000; c1_data = 8'h00; c1_flags = 3'b000;
        eng_valid = 1'b0; eng_match = 1'b0; eng_index = 5'd0;
        @(negedge clk);
        chk("rst_gnt", 32'(c_gnt), 32'(2'b00));
        chk("rst_ack", 32'(c_ack), 32'(2'b00));
        chk("rst_eng", 32'({eng_chardata, eng_isstring, eng_ispattern}), 32'(10'd0));
        chk("rst_res", 32'({res_valid, res_id, res_match, res_index, res_err}), 32'(9'd0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        $display("reset checked");

        // ---- job A cycle by cycle: IDLE, ARB, SYNC, 8 bytes, WAIT (stale strobe), RESP ----
        tbl[0]  = mk(2'b01, 8'h00, 3'b000, 1'b0, 1'b0, 5'd0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tbl[1]  = mk(2'b01, 8'h61, 3'b001, 1'b0, 1'b0, 5'd0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tbl[2]  = mk(2'b01, 8'h61, 3'b001, 1'b0, 1'b0, 5'd0, 2'b01, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tbl[3]  = mk(2'b01, 8'h61, 3'b001, 1'b1, 1'b0, 5'd0, 2'b01, 2'b01, 8'h61, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tbl[4]  = mk(2'b01, 8'h62, 3'b001, 1'b0, 1'b0, 5'd0, 2'b01, 2'b01, 8'h62, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tbl[5]  = mk(2'b01, 8'h20, 3'b001, 1'b0, 1'b0, 5'd0, 2'b01, 2'b01, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tbl[6]  = mk(2'b01, 8'h63, 3'b001, 1'b0, 1'b0, 5'd0, 2'b01, 2'b01, 8'h63, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tbl[7]  = mk(2'b01, 8'h61, 3'b001, 1'b0, 1'b0, 5'd0, 2'b01, 2'b01, 8'h61, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tbl[8]  = mk(2'b01, 8'h5e, 3'b010, 1'b0, 1'b0, 5'd0, 2'b01, 2'b01, 8'h5e, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tbl[9]  = mk(2'b01, 8'h63, 3'b010, 1'b0, 1'b0, 5'd0, 2'b01, 2'b01, 8'h63, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tbl[10] = mk(2'b01, 8'h61, 3'b110, 1'b0, 1'b0, 5'd0, 2'b01, 2'b01, 8'h61, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tbl[11] = mk(2'b01, 8'h00, 3'b000, 1'b1, 1'b0, 5'd7, 2'b01, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tbl[12] = mk(2'b01, 8'h00, 3'b000, 1'b0, 1'b0, 5'd0, 2'b01, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tbl[13] = mk(2'b01, 8'h00, 3'b000, 1'b1, 1'b1, 5'd3, 2'b01, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tbl[14] = mk(2'b00, 8'h00, 3'b000, 1'b0, 1'b0, 5'd0, 2'b01, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0);
        tbl[15] = mk(2'b00, 8'h00, 3'b000, 1'b0, 1'b0, 5'd0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

        for (int v = 0; v < 16; v++) begin
            c_req = tbl[v].req;
            c0_data = tbl[v].d0; c0_flags = tbl[v].f0;
            c1_data = 8'h00; c1_flags = 3'b000;
            eng_valid = tbl[v].ev; eng_match = tbl[v].em; eng_index = tbl[v].ei;
            @(negedge clk);
            $display("vec %0d: gnt=%b ack=%b eng=%h/%b%b res_valid=%b", v, c_gnt, c_ack,
                     eng_chardata, eng_isstring, eng_ispattern, res_valid);
            chk($sformatf("v%0d_gnt", v), 32'(c_gnt), 32'(tbl[v].gnt));
            chk($sformatf("v%0d_ack", v), 32'(c_ack), 32'(tbl[v].ack));
            chk($sformatf("v%0d_chardata", v), 32'(eng_chardata), 32'(tbl[v].cd));
            chk($sformatf("v%0d_isstring", v), 32'(eng_isstring), 32'(tbl[v].es));
            chk($sformatf("v%0d_ispattern", v), 32'(eng_ispattern), 32'(tbl[v].ep));
            chk($sformatf("v%0d_res_valid", v), 32'(res_valid), 32'(tbl[v].rv));
            if (tbl[v].rv) begin
                chk($sformatf("v%0d_res_id", v), 32'(res_id), 32'(tbl[v].rid));
                chk($sformatf("v%0d_res_match", v), 32'(res_match), 32'(tbl[v].rm));
                chk($sformatf("v%0d_res_index", v), 32'(res_index), 32'(tbl[v].ri));
                chk($sformatf("v%0d_res_err", v), 32'(res_err), 32'(tbl[v].re));
            end
            @(posedge clk);
            #1;
        end

        // ---- both request right after c0 was served: c1 wins the tie, then c0 ----
        load_pair();
        clear_stats();
        eng_on = 1'b1; eng_per = 7; eng_m = 1'b1; eng_i = 5'd1;
        c_req = 2'b11;
        run_until(2, 300, "rr_after_c0");
        chk("rr_after_c0_first_gnt", 32'(first_gnt), 32'(2'b10));
        chk_res("rr_after_c0_r0", 0, 1'b1, 1'b1, 5'd1, 1'b0);
        chk_res("rr_after_c0_r1", 1, 1'b0, 1'b1, 5'd1, 1'b0);
        chk("rr_after_c0_acks", 32'({acks0[7:0], acks1[7:0]}), 32'({8'd3, 8'd3}));

        // ---- fresh reset, both request at once: c0 first, then c1 ----
        do_reset();
        load_pair();
        clear_stats();
        c_req = 2'b11;
        run_until(2, 300, "rr_fresh");
        chk("rr_fresh_first_gnt", 32'(first_gnt), 32'(2'b01));
        chk_res("rr_fresh_r0", 0, 1'b0, 1'b1, 5'd1, 1'b0);
        chk_res("rr_fresh_r1", 1, 1'b1, 1'b1, 5'd1, 1'b0);
        chk("rr_fresh_fwd_n", 32'(fwd_n), 32'(6));
        for (int i = 0; i < 6; i++) chk($sformatf("rr_fresh_byte%0d", i), 32'(fwd_log[i]), 32'(exp_b[i]));

        // ---- engine goes silent after Load: timeout in WAIT ----
        job0[0] = {3'b001, 8'h61}; job0[1] = {3'b110, 8'h62}; len0 = 2; len1 = 0;
        clear_stats();
        eng_on = 1'b1; eng_m = 1'b1; eng_i = 5'd5; kill_after_ack = 1'b1;
        c_req = 2'b01;
        run_until(1, 3000, "timeout");
        kill_after_ack = 1'b0;
        chk_res("timeout_r0", 0, 1'b0, 1'b0, 5'd0, 1'b1);
        chk("timeout_latency", 32'(res_cyc - last_ack_cyc), 32'(TIMEOUT + 1));

        // ---- c1: one string byte then 10 pattern bytes, only 8 reach the engine ----
        job1[0] = {3'b001, 8'h71};
        for (int i = 1; i < 10; i++) job1[i] = {3'b010, 8'(8'h30 + i)};
        job1[10] = {3'b110, 8'h3a};
        len1 = 11; len0 = 0;
        clear_stats();
        eng_on = 1'b1; eng_m = 1'b1; eng_i = 5'd4;
        c_req = 2'b10;
        run_until(1, 300, "pat_ovf");
        chk("pat_ovf_acks", 32'(acks1), 32'(11));
        chk("pat_ovf_pat_cycles", 32'(pat_cyc), 32'(8));
        chk("pat_ovf_str_cycles", 32'(str_cyc), 32'(1));
        chk_res("pat_ovf_r0", 0, 1'b1, 1'b0, 5'd0, 1'b1);

        // ---- bubble after 3 string bytes ends the transfer ----
        job0[0] = {3'b001, 8'h61}; job0[1] = {3'b001, 8'h62}; job0[2] = {3'b001, 8'h63};
        job0[3] = {3'b000, 8'h00};
        len0 = 4; len1 = 0;
        clear_stats();
        eng_m = 1'b1; eng_i = 5'd2;
        c_req = 2'b01;
        run_until(1, 300, "bubble");
        chk("bubble_acks", 32'(acks0), 32'(4));
        chk("bubble_str_cycles", 32'(str_cyc), 32'(3));
        chk("bubble_pat_cycles", 32'(pat_cyc), 32'(0));
        chk_res("bubble_r0", 0, 1'b0, 1'b0, 5'd0, 1'b1);

        // ---- string byte after a pattern byte is dropped, transfer continues ----
        job0[0] = {3'b001, 8'h61}; job0[1] = {3'b001, 8'h62}; job0[2] = {3'b010, 8'h78};
        job0[3] = {3'b001, 8'h63}; job0[4] = {3'b110, 8'h79};
        len0 = 5; len1 = 0;
        clear_stats();
        c_req = 2'b01;
        run_until(1, 300, "order");
        chk("order_acks", 32'(acks0), 32'(5));
        chk("order_str_cycles", 32'(str_cyc), 32'(2));
        chk("order_pat_cycles", 32'(pat_cyc), 32'(2));
        chk("order_fwd_n", 32'(fwd_n), 32'(4));
        for (int i = 0; i < 4; i++) chk($sformatf("order_byte%0d", i), 32'(fwd_log[i]), 32'(exp_f[i]));
        chk_res("order_r0", 0, 1'b0, 1'b0, 5'd0, 1'b1);

        // ---- reset in the middle of XFER, then a clean job ----
        for (int i = 0; i < 8; i++) job0[i] = {3'b001, 8'h73};
        job0[8] = {3'b110, 8'h70};
        len0 = 9; len1 = 0;
        clear_stats();
        c_req = 2'b01;
        begin
            int k;
            k = 0;
            while (acks0 < 3 && k < 100) begin
                step();
                k++;
            end
        end
        chk("midrst_reached_xfer", 32'(acks0 >= 3), 32'(1));
        reset = 1'b1;
        #1;
        chk("midrst_gnt", 32'(c_gnt), 32'(2'b00));
        chk("midrst_ack", 32'(c_ack), 32'(2'b00));
        chk("midrst_eng", 32'({eng_chardata, eng_isstring, eng_ispattern}), 32'(10'd0));
        chk("midrst_res_valid", 32'(res_valid), 32'(0));
        @(posedge clk);
        #1;
        load_job_a();
        clear_stats();
        eng_m = 1'b1; eng_i = 5'd3;
        c_req = 2'b01;
        reset = 1'b0;
        run_until(1, 300, "after_rst");
        chk("after_rst_acks", 32'(acks0), 32'(8));
        chk("after_rst_fwd_n", 32'(fwd_n), 32'(8));
        for (int i = 0; i < 8; i++) chk($sformatf("after_rst_byte%0d", i), 32'(fwd_log[i]), 32'(exp_a[i]));
        chk_res("after_rst_r0", 0, 1'b0, 1'b1, 5'd3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
